// File: rtl/neuron_scheduler.sv
// neuron_scheduler: an 8-neuron layer with binary inputs and threshold activation.
// It is evaluated on one shared multiply-accumulate path: 8 MAC cycles plus 1 ACT cycle per neuron.
module neuron_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [10:0] cfg_wdata,
  output logic        cfg_err,
  input  logic        start,
  input  logic [7:0]  x_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  y_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [7:0]  weight_r [64];
  logic [10:0] thresh_r [8];
  logic [7:0]  x_r;
  logic [6:0]  result_r;
  logic [10:0] acc_r;
  logic [2:0]  n_r;
  logic [2:0]  i_r;

  logic [7:0]  w_sel_s;
  logic [10:0] th_sel_s;
  logic [10:0] addend_s;
  logic        hit_s;

  function automatic logic is_weight_addr(input logic [6:0] addr);
    return addr[6] == 1'b0;
  endfunction

  function automatic logic is_thresh_addr(input logic [6:0] addr);
    return addr[6:3] == 4'b1000;
  endfunction

  // Operand selection for the shared MAC and the activation compare.
  always_comb begin
    w_sel_s  = weight_r[{n_r, i_r}];
    th_sel_s = thresh_r[n_r];
    if (x_r[i_r]) begin
      addend_s = {3'b000, w_sel_s};
    end else begin
      addend_s = 11'd0;
    end
    hit_s = (acc_r >= th_sel_s);
  end

  // Configuration storage: writes only land while idle; unmapped addresses fall through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) weight_r[k] <= 8'd0;
      for (int k = 0; k < 8; k++) thresh_r[k] <= 11'd0;
    end else if (cfg_we && (state_r == IDLE)) begin
      if (is_weight_addr(cfg_addr)) begin
        weight_r[cfg_addr[5:0]] <= cfg_wdata[7:0];
      end else if (is_thresh_addr(cfg_addr)) begin
        thresh_r[cfg_addr[2:0]] <= cfg_wdata;
      end
    end
  end

  // Evaluation FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      x_r      <= 8'd0;
      result_r <= 7'd0;
      acc_r    <= 11'd0;
      n_r      <= 3'd0;
      i_r      <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      y_out    <= 8'h00;
    end else begin
      cfg_err <= cfg_we && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_r     <= x_in;
            acc_r   <= 11'd0;
            n_r     <= 3'd0;
            i_r     <= 3'd0;
            busy    <= 1'b1;
            state_r <= MAC;
          end
        end
        MAC: begin
          acc_r <= acc_r + addend_s;
          i_r   <= i_r + 3'd1;
          if (i_r == 3'd7) begin
            state_r <= ACT;
          end
        end
        ACT: begin
          acc_r <= 11'd0;
          i_r   <= 3'd0;
          if (n_r == 3'd7) begin
            // Neuron 7's bit goes straight into y_out so that y_out updates together with done.
            y_out   <= {hit_s, result_r};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            result_r[n_r] <= hit_s;
            n_r     <= n_r + 3'd1;
            state_r <= MAC;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed self-checking bench for neuron_scheduler; expected values are hand-computed.
module tb_neuron_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [6:0]  cfg_addr = 7'd0;
  logic [10:0] cfg_wdata = 11'd0;
  logic        cfg_err;
  logic        start = 1'b0;
  logic [7:0]  x_in = 8'h00;
  logic        busy;
  logic        done;
  logic [7:0]  y_out;

  int total = 0;
  int bad = 0;

  neuron_scheduler dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .start(start), .x_in(x_in), .busy(busy), .done(done), .y_out(y_out)
  );

  always #5 clk = ~clk;

  task automatic cfg_write(input logic [6:0] addr, input logic [10:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Wait from the first negedge after the start edge until done, with a bounded loop.
  task automatic wait_done(output int busy_cyc, output bit got_done);
    busy_cyc = 0; got_done = 1'b0;
    for (int k = 0; k < 200 && !got_done; k++) begin
      if (done) got_done = 1'b1;
      else begin
        if (busy) busy_cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_eval(input logic [7:0] x, output int busy_cyc, output bit got_done);
    @(negedge clk);
    start = 1'b1; x_in = x;
    @(negedge clk);
    start = 1'b0; x_in = ~x;
    wait_done(busy_cyc, got_done);
  endtask

  task automatic test_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    total++; if (y_out !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", y_out); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_defaults();
    int bc; bit gd;
    run_eval(8'hA5, bc, gd);
    total++; if (gd !== 1'b1) begin bad++; $display("FAIL def_done got=%b exp=1", gd); end
    total++; if (bc != 72) begin bad++; $display("FAIL def_busy_cycles got=%0d exp=72", bc); end
    total++; if (y_out !== 8'hFF) begin bad++; $display("FAIL def_y got=%h exp=ff", y_out); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL def_done_pulse got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL def_idle_busy got=%b exp=0", busy); end
    total++; if (y_out !== 8'hFF) begin bad++; $display("FAIL def_y_hold got=%h exp=ff", y_out); end
  endtask

  task automatic test_neuron0();
    int bc; bit gd;
    for (int k = 0; k < 8; k++) cfg_write(7'(k), 11'd1);
    cfg_write(7'd64, 11'd5);
    for (int k = 65; k < 72; k++) cfg_write(7'(k), 11'd1);
    cfg_write(7'd100, 11'd0);
    #1;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL n0_unmapped_err got=%b exp=0", cfg_err); end
    run_eval(8'h1F, bc, gd);
    total++; if (gd !== 1'b1 || y_out !== 8'h01) begin bad++; $display("FAIL n0_1f got=%h exp=01", y_out); end
    run_eval(8'h0F, bc, gd);
    total++; if (gd !== 1'b1 || y_out !== 8'h00) begin bad++; $display("FAIL n0_0f got=%h exp=00", y_out); end
    // A start together with a threshold write must use the new threshold of 4.
    @(negedge clk);
    start = 1'b1; x_in = 8'h0F; cfg_we = 1'b1; cfg_addr = 7'd64; cfg_wdata = 11'd4;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0; x_in = 8'h00;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL n0_same_cycle_err got=%b exp=0", cfg_err); end
    wait_done(bc, gd);
    total++; if (gd !== 1'b1 || y_out !== 8'h01) begin bad++; $display("FAIL n0_same_cycle_y got=%h exp=01", y_out); end
  endtask

  task automatic test_max();
    int bc; bit gd;
    for (int k = 0; k < 64; k++) cfg_write(7'(k), 11'd255);
    for (int k = 64; k < 72; k++) cfg_write(7'(k), 11'd2040);
    run_eval(8'hFF, bc, gd);
    total++; if (gd !== 1'b1 || y_out !== 8'hFF) begin bad++; $display("FAIL max_2040 got=%h exp=ff", y_out); end
    for (int k = 64; k < 72; k++) cfg_write(7'(k), 11'd2041);
    run_eval(8'hFF, bc, gd);
    total++; if (gd !== 1'b1 || y_out !== 8'h00) begin bad++; $display("FAIL max_2041 got=%h exp=00", y_out); end
  endtask

  task automatic test_busy_write();
    int bc; bit gd;
    for (int k = 64; k < 72; k++) cfg_write(7'(k), 11'd2040);
    @(negedge clk);
    start = 1'b1; x_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 7'd0; cfg_wdata = 11'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL bw_err_pulse got=%b exp=1", cfg_err); end
    @(negedge clk);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL bw_err_clear got=%b exp=0", cfg_err); end
    wait_done(bc, gd);
    total++; if (gd !== 1'b1 || y_out !== 8'hFF) begin bad++; $display("FAIL bw_current_y got=%h exp=ff", y_out); end
    run_eval(8'hFF, bc, gd);
    total++; if (gd !== 1'b1 || y_out !== 8'hFF) begin bad++; $display("FAIL bw_weight_kept got=%h exp=ff", y_out); end
  endtask

  task automatic test_reset_mid();
    int bc; bit gd; int dones;
    @(negedge clk);
    start = 1'b1; x_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 29; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    total++; if (y_out !== 8'h00) begin bad++; $display("FAIL rm_y got=%h exp=00", y_out); end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL rm_no_done got=%0d exp=0", dones); end
    run_eval(8'h3C, bc, gd);
    total++; if (gd !== 1'b1 || bc != 72 || y_out !== 8'hFF) begin
      bad++; $display("FAIL rm_rerun got=y%h/c%0d exp=yff/c72", y_out, bc);
    end
  endtask

  task automatic test_double_start();
    int bc; bit gd; int dones;
    @(negedge clk);
    start = 1'b1; x_in = 8'h81;
    @(negedge clk);
    start = 1'b0;
    bc = 0; gd = 1'b0;
    for (int k = 0; k < 200 && !gd; k++) begin
      if (done) gd = 1'b1;
      else begin
        if (busy) bc++;
        start = (k == 10);
        @(negedge clk);
      end
    end
    start = 1'b0;
    total++; if (gd !== 1'b1 || bc != 72) begin bad++; $display("FAIL ds_timing got=c%0d exp=c72", bc); end
    // A start presented in DONE must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ds_start_in_done got=%b exp=0", busy); end
    dones = 0;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL ds_extra_done got=%0d exp=0", dones); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_neuron0();
    test_max();
    test_busy_write();
    test_reset_mid();
    test_double_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 The block SHALL provide these ports, clock and reset first:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- cfg_we  input  1  configuration write strobe
- cfg_addr  input  7  0-63 weight (neuron n, input i at n*8+i); 64-71 threshold of neuron addr-64; 72-127 unmapped
- cfg_wdata  input  11  write data; weights use bits [7:0]
- cfg_err  output  1  one-cycle pulse: write rejected
- start  input  1  request one 8-neuron evaluation
- x_in  input  8  binary input vector
- busy  output  1  evaluation in progress
- done  output  1  one-cycle completion pulse
- y_out  output  8  registered neuron outputs, bit n = neuron n

Function
REQ-002 The block SHALL hold 64 8-bit unsigned weights and 8 11-bit unsigned thresholds, evaluated by one shared multiply-accumulate path.
REQ-003 The FSM SHALL have states IDLE, MAC, ACT, DONE.
REQ-004 In IDLE, start=1 SHALL capture x_in into an internal register, clear the 11-bit accumulator, set neuron index n=0 and input index i=0, and enter MAC.
REQ-005 Each MAC cycle SHALL add weight[n*8+i] to the accumulator when captured x[i]=1, add 0 otherwise, then increment i.
- After i=7 the state SHALL go to ACT.
REQ-006 Accumulator width SHALL be 11 bits; the maximum sum of 2040 SHALL never overflow.
REQ-007 ACT SHALL take one cycle and set result bit n = (accumulator >= threshold[n]).
- It SHALL then clear the accumulator and set i=0.
- If n<7, it SHALL increment n and go to MAC; if n=7, it SHALL go to DONE.
REQ-008 DONE SHALL take one cycle.
- It SHALL assert done=1 and load all 8 result bits into y_out at once.
- It SHALL then return to IDLE.
REQ-009 busy SHALL be 1 exactly in MAC and ACT.
REQ-010 Timing for a start accepted at edge E:
- busy SHALL rise after E.
- done SHALL be high in the cycle after edge E+72, i.e. 72 cycles of busy followed by 1 cycle of done.
REQ-011 start SHALL be ignored outside IDLE, including in DONE.
REQ-012 y_out SHALL hold its value between done pulses.
- x_in changes after the capture edge SHALL not affect the evaluation in progress.
REQ-013 Configuration writes behave as follows:
- A write with cfg_we=1 in IDLE to a mapped address SHALL commit at that edge.
- Unmapped addresses SHALL be silently ignored.
REQ-014 A write with cfg_we=1 outside IDLE SHALL be dropped, and cfg_err SHALL pulse high for one cycle after that edge.
- cfg_err SHALL stay 0 for all other writes.
REQ-015 If start and cfg_we are both high in IDLE, the write SHALL commit and the started evaluation SHALL use the new value.

Reset
REQ-016 While rst=1, regardless of clk, the block SHALL:
- force state IDLE
- set busy=0, done=0, cfg_err=0, y_out=8'h00
- clear all weights, thresholds, the accumulator, n, i and the captured input.
REQ-017 Reset asserted mid-evaluation SHALL abort it with no done pulse and no y_out update.
REQ-018 After rst falls, the first start SHALL be accepted at the next rising edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Defaults: reset, then start with x_in=8'hA5 -> done 72 cycles after busy rises; y_out=8'hFF, since 0>=0 for every neuron.
- Neuron 0: weights 0-7 =1, threshold[0]=5, all other thresholds=1, other weights 0. x_in=8'h1F -> y_out=8'h01; x_in=8'h0F -> y_out=8'h00.
- Max arithmetic: all weights 255, x_in=8'hFF. threshold=2040 -> y_out=8'hFF; threshold=2041 -> y_out=8'h00.
- Busy write: write cfg_addr=0 while busy -> cfg_err pulses once; the weight is unchanged on the next run; y_out of the current run is unaffected.
- Reset mid-run: assert rst 30 cycles after start -> busy=0 and y_out=8'h00 immediately; no done pulse; a later start completes normally.
- Double start: start pulsed again 10 cycles into a run -> exactly one done pulse; timing per REQ-010 from the first start.
